// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, ALU and result-select encodings,
// the decoded control bundle and the funct3 -> ALU operation mapping.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  typedef struct packed {
    alu_ctrl_e   alu_ctrl;
    logic        alu_src;
    logic        alu_a_pc;
    result_src_e result_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{ALU_ADD, 1'b0, 1'b0, RES_ALU,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_ctrl_e alu_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_reg_file.sv
// 32-entry integer register file: two asynchronous read ports with
// write-through from the writeback port, x0 hardwired to zero.
module reg_file
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREGS];

  // Reset clears every entry and wins over a coincident writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports bypass the array when the same register is being written
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (we && waddr != 5'd0 && waddr == raddr1) rdata1 = wdata;
    if (we && waddr != 5'd0 && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: control decode, immediate generation, register file
// read, load-use hazard detection and the decode/execute pipeline register.
module instr_decode
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] next_pc_in,
  input  logic            valid_in,
  input  logic            reg_write_wb,
  input  logic [4:0]      rd_wb,
  input  logic [XLEN-1:0] result_wb,
  output logic [XLEN-1:0] rs1_data_exec,
  output logic [XLEN-1:0] rs2_data_exec,
  output logic [XLEN-1:0] imm_exec,
  output logic [4:0]      rs1_exec,
  output logic [4:0]      rs2_exec,
  output logic [4:0]      rd_exec,
  output logic [2:0]      funct3_exec,
  output logic [3:0]      alu_ctrl_exec,
  output logic            alu_src_exec,
  output logic            alu_a_pc_exec,
  output logic [1:0]      result_src_exec,
  output logic            reg_write_exec,
  output logic            mem_read_exec,
  output logic            mem_write_exec,
  output logic            branch_exec,
  output logic            jump_exec,
  output logic            illegal_exec,
  output logic [XLEN-1:0] pc_exec,
  output logic [XLEN-1:0] next_pc_exec,
  output logic            valid_exec,
  output logic            hazard_stall
);

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_in[6:0];
  assign rd     = instr_in[11:7];
  assign funct3 = instr_in[14:12];
  assign rs1    = instr_in[19:15];
  assign rs2    = instr_in[24:20];
  assign funct7 = instr_in[31:25];

  logic [XLEN-1:0] rs1_data, rs2_data;

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (reg_write_wb),
    .waddr  (rd_wb),
    .wdata  (result_wb),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  ctrl_t    ctrl;
  imm_sel_e imm_sel;

  // Control decode; illegal encodings are stripped of all side-effecting flags
  always_comb begin
    ctrl    = CTRL_NOP;
    imm_sel = IMM_I;
    case (opcode)
      OP_LUI: begin
        ctrl.alu_ctrl = ALU_PASS_B; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        imm_sel = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.alu_a_pc = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        imm_sel = IMM_U;
      end
      OP_JAL: begin
        ctrl.alu_a_pc = 1'b1; ctrl.alu_src = 1'b1; ctrl.jump = 1'b1;
        ctrl.reg_write = 1'b1; ctrl.result_src = RES_PC4;
        imm_sel = IMM_J;
      end
      OP_JALR: begin
        ctrl.alu_src = 1'b1; ctrl.jump = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.illegal = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        ctrl.alu_ctrl = ALU_SUB; ctrl.branch = 1'b1;
        imm_sel = IMM_B;
        ctrl.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_LOAD: begin
        ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
        imm_sel = IMM_S;
        ctrl.illegal = (funct3 > 3'b010);
      end
      OP_IMM: begin
        ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl = alu_op(funct3, (funct3 == 3'b101) && instr_in[30]);
        if (funct3 == 3'b001) ctrl.illegal = (funct7 != 7'h00);
        if (funct3 == 3'b101) ctrl.illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OP_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_op(funct3, instr_in[30]);
        ctrl.illegal   = !((funct7 == 7'h00) ||
                           (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      default: ctrl.illegal = 1'b1;
    endcase
    if (ctrl.illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
    end
  end

  logic [XLEN-1:0] imm;

  // Immediate generation, always sign-extended from instr[31]
  always_comb begin
    case (imm_sel)
      IMM_S:   imm = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      IMM_B:   imm = {{(XLEN-12){instr_in[31]}}, instr_in[7], instr_in[30:25],
                      instr_in[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-32){instr_in[31]}}, instr_in[31:12], 12'b0};
      IMM_J:   imm = {{(XLEN-20){instr_in[31]}}, instr_in[19:12], instr_in[20],
                      instr_in[30:21], 1'b0};
      default: imm = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
    endcase
  end

  ctrl_t ctrl_exec;

  // ---- decode / execute boundary ----
  // Priority: reset > flush > stall > bubble (valid_in low) > load
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !valid_in)) begin
      ctrl_exec     <= CTRL_NOP;
      rs1_data_exec <= '0;
      rs2_data_exec <= '0;
      imm_exec      <= '0;
      rs1_exec      <= '0;
      rs2_exec      <= '0;
      rd_exec       <= '0;
      funct3_exec   <= '0;
      pc_exec       <= '0;
      next_pc_exec  <= '0;
      valid_exec    <= 1'b0;
    end else if (!stall) begin
      ctrl_exec     <= ctrl;
      rs1_data_exec <= rs1_data;
      rs2_data_exec <= rs2_data;
      imm_exec      <= imm;
      rs1_exec      <= rs1;
      rs2_exec      <= rs2;
      rd_exec       <= rd;
      funct3_exec   <= funct3;
      pc_exec       <= pc_in;
      next_pc_exec  <= next_pc_in;
      valid_exec    <= 1'b1;
    end
  end

  assign alu_ctrl_exec   = ctrl_exec.alu_ctrl;
  assign alu_src_exec    = ctrl_exec.alu_src;
  assign alu_a_pc_exec   = ctrl_exec.alu_a_pc;
  assign result_src_exec = ctrl_exec.result_src;
  assign reg_write_exec  = ctrl_exec.reg_write;
  assign mem_read_exec   = ctrl_exec.mem_read;
  assign mem_write_exec  = ctrl_exec.mem_write;
  assign branch_exec     = ctrl_exec.branch;
  assign jump_exec       = ctrl_exec.jump;
  assign illegal_exec    = ctrl_exec.illegal;

  // Conservative load-use check: compares rs2 even when the instruction ignores it
  assign hazard_stall = valid_in && valid_exec && ctrl_exec.mem_read &&
                        (rd_exec != 5'd0) && ((rd_exec == rs1) || (rd_exec == rs2));

endmodule

// File: tb/tb_instr_decode.sv
// Directed self-checking bench for instr_decode.
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        reset, flush, stall, valid_in, reg_write_wb;
  logic [31:0] instr_in, pc_in, next_pc_in, result_wb;
  logic [4:0]  rd_wb;
  logic [31:0] rs1_data_exec, rs2_data_exec, imm_exec, pc_exec, next_pc_exec;
  logic [4:0]  rs1_exec, rs2_exec, rd_exec;
  logic [2:0]  funct3_exec;
  logic [3:0]  alu_ctrl_exec;
  logic [1:0]  result_src_exec;
  logic        alu_src_exec, alu_a_pc_exec, reg_write_exec, mem_read_exec;
  logic        mem_write_exec, branch_exec, jump_exec, illegal_exec, valid_exec;
  logic        hazard_stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_decode dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .instr_in(instr_in), .pc_in(pc_in), .next_pc_in(next_pc_in), .valid_in(valid_in),
    .reg_write_wb(reg_write_wb), .rd_wb(rd_wb), .result_wb(result_wb),
    .rs1_data_exec(rs1_data_exec), .rs2_data_exec(rs2_data_exec), .imm_exec(imm_exec),
    .rs1_exec(rs1_exec), .rs2_exec(rs2_exec), .rd_exec(rd_exec),
    .funct3_exec(funct3_exec), .alu_ctrl_exec(alu_ctrl_exec),
    .alu_src_exec(alu_src_exec), .alu_a_pc_exec(alu_a_pc_exec),
    .result_src_exec(result_src_exec), .reg_write_exec(reg_write_exec),
    .mem_read_exec(mem_read_exec), .mem_write_exec(mem_write_exec),
    .branch_exec(branch_exec), .jump_exec(jump_exec), .illegal_exec(illegal_exec),
    .pc_exec(pc_exec), .next_pc_exec(next_pc_exec), .valid_exec(valid_exec),
    .hazard_stall(hazard_stall)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    instr_in = instr; pc_in = pc; next_pc_in = pc + 32'd4; valid_in = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; stall = 1'b0; valid_in = 1'b1; reg_write_wb = 1'b0;
    rd_wb = 5'd0; result_wb = 32'd0; issue(32'h00500093, 32'h100);
    tick(); tick();
    checks++; if ({rs1_data_exec, rs2_data_exec, imm_exec, pc_exec, next_pc_exec} !== 160'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {rs1_data_exec, rs2_data_exec, imm_exec, pc_exec, next_pc_exec}); end
    checks++; if ({rs1_exec, rs2_exec, rd_exec, funct3_exec, alu_ctrl_exec, result_src_exec} !== 24'd0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {rs1_exec, rs2_exec, rd_exec, funct3_exec, alu_ctrl_exec, result_src_exec}); end
    checks++; if ({alu_src_exec, alu_a_pc_exec, reg_write_exec, mem_read_exec, mem_write_exec, branch_exec, jump_exec, illegal_exec, valid_exec, hazard_stall} !== 10'd0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {alu_src_exec, alu_a_pc_exec, reg_write_exec, mem_read_exec, mem_write_exec, branch_exec, jump_exec, illegal_exec, valid_exec, hazard_stall}); end
    reset = 1'b0;
  endtask

  task automatic test_addi;
    issue(32'h00500093, 32'h100);   // addi x1,x0,5
    tick();
    checks++; if (imm_exec !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h exp=5", imm_exec); end
    checks++; if (rd_exec !== 5'd1) begin failures++; $display("FAIL addi_rd got=%0d exp=1", rd_exec); end
    checks++; if (alu_ctrl_exec !== 4'd0 || alu_src_exec !== 1'b1) begin failures++; $display("FAIL addi_alu got=%0d/%b exp=0/1", alu_ctrl_exec, alu_src_exec); end
    checks++; if (reg_write_exec !== 1'b1 || valid_exec !== 1'b1 || illegal_exec !== 1'b0) begin failures++; $display("FAIL addi_flags got=%b%b%b exp=110", reg_write_exec, valid_exec, illegal_exec); end
    checks++; if (pc_exec !== 32'h100 || next_pc_exec !== 32'h104) begin failures++; $display("FAIL addi_pc got=%h/%h exp=100/104", pc_exec, next_pc_exec); end
  endtask

  task automatic test_writethrough;
    reg_write_wb = 1'b1; rd_wb = 5'd1; result_wb = 32'h00001234;
    issue(32'h00108133, 32'h104);   // add x2,x1,x1
    tick();
    reg_write_wb = 1'b0;
    checks++; if (rs1_data_exec !== 32'h1234 || rs2_data_exec !== 32'h1234) begin failures++; $display("FAIL wt_data got=%h/%h exp=1234/1234", rs1_data_exec, rs2_data_exec); end
    checks++; if (rd_exec !== 5'd2 || alu_ctrl_exec !== 4'd0 || alu_src_exec !== 1'b0) begin failures++; $display("FAIL wt_ctrl got=%0d/%0d/%b exp=2/0/0", rd_exec, alu_ctrl_exec, alu_src_exec); end
    tick();   // same instruction, now read from the array
    checks++; if (rs1_data_exec !== 32'h1234 || rs2_data_exec !== 32'h1234) begin failures++; $display("FAIL rf_stored got=%h/%h exp=1234/1234", rs1_data_exec, rs2_data_exec); end
  endtask

  task automatic test_store_illegal;
    issue(32'h0020A423, 32'h108);   // sw x2,8(x1)
    tick();
    checks++; if (imm_exec !== 32'd8 || funct3_exec !== 3'd2) begin failures++; $display("FAIL sw_imm got=%h/%0d exp=8/2", imm_exec, funct3_exec); end
    checks++; if (mem_write_exec !== 1'b1 || reg_write_exec !== 1'b0 || mem_read_exec !== 1'b0) begin failures++; $display("FAIL sw_flags got=%b%b%b exp=100", mem_write_exec, reg_write_exec, mem_read_exec); end
    checks++; if (rs1_data_exec !== 32'h1234) begin failures++; $display("FAIL sw_rs1 got=%h exp=1234", rs1_data_exec); end
    issue(32'hFFFFFFFF, 32'h10C);
    tick();
    checks++; if (illegal_exec !== 1'b1 || valid_exec !== 1'b1) begin failures++; $display("FAIL ill_flag got=%b%b exp=11", illegal_exec, valid_exec); end
    checks++; if ({reg_write_exec, mem_read_exec, mem_write_exec, branch_exec, jump_exec} !== 5'd0) begin failures++; $display("FAIL ill_enables got=%b exp=00000", {reg_write_exec, mem_read_exec, mem_write_exec, branch_exec, jump_exec}); end
    issue(32'h021080B3, 32'h110);   // mul: OP with funct7=0x01
    tick();
    checks++; if (illegal_exec !== 1'b1 || reg_write_exec !== 1'b0) begin failures++; $display("FAIL ill_funct7 got=%b%b exp=10", illegal_exec, reg_write_exec); end
  endtask

  task automatic test_formats;
    issue(32'h12345237, 32'h200);   // lui x4,0x12345
    tick();
    checks++; if (imm_exec !== 32'h12345000 || alu_ctrl_exec !== 4'd10 || reg_write_exec !== 1'b1) begin failures++; $display("FAIL lui got=%h/%0d/%b exp=12345000/10/1", imm_exec, alu_ctrl_exec, reg_write_exec); end
    issue(32'hFFDFF0EF, 32'h204);   // jal x1,-4
    tick();
    checks++; if (imm_exec !== 32'hFFFFFFFC || jump_exec !== 1'b1 || result_src_exec !== 2'd2) begin failures++; $display("FAIL jal got=%h/%b/%0d exp=fffffffc/1/2", imm_exec, jump_exec, result_src_exec); end
    checks++; if (alu_a_pc_exec !== 1'b1 || reg_write_exec !== 1'b1 || rd_exec !== 5'd1) begin failures++; $display("FAIL jal_ctrl got=%b/%b/%0d exp=1/1/1", alu_a_pc_exec, reg_write_exec, rd_exec); end
    issue(32'hFE209EE3, 32'h208);   // bne x1,x2,-4
    tick();
    checks++; if (imm_exec !== 32'hFFFFFFFC || branch_exec !== 1'b1 || alu_ctrl_exec !== 4'd1) begin failures++; $display("FAIL bne got=%h/%b/%0d exp=fffffffc/1/1", imm_exec, branch_exec, alu_ctrl_exec); end
    checks++; if (funct3_exec !== 3'd1 || reg_write_exec !== 1'b0) begin failures++; $display("FAIL bne_ctrl got=%0d/%b exp=1/0", funct3_exec, reg_write_exec); end
    issue(32'h402081B3, 32'h20C);   // sub x3,x1,x2
    tick();
    checks++; if (alu_ctrl_exec !== 4'd1 || rd_exec !== 5'd3 || alu_src_exec !== 1'b0) begin failures++; $display("FAIL sub got=%0d/%0d/%b exp=1/3/0", alu_ctrl_exec, rd_exec, alu_src_exec); end
    issue(32'h4030D293, 32'h210);   // srai x5,x1,3
    tick();
    checks++; if (alu_ctrl_exec !== 4'd7 || imm_exec !== 32'h403 || alu_src_exec !== 1'b1) begin failures++; $display("FAIL srai got=%0d/%h/%b exp=7/403/1", alu_ctrl_exec, imm_exec, alu_src_exec); end
  endtask

  task automatic test_hazard;
    issue(32'h00002083, 32'h300);   // lw x1,0(x0)
    tick();
    checks++; if (mem_read_exec !== 1'b1 || result_src_exec !== 2'd1) begin failures++; $display("FAIL lw got=%b/%0d exp=1/1", mem_read_exec, result_src_exec); end
    issue(32'h00108133, 32'h304);   // add x2,x1,x1
    #1;
    checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL hazard_rd1 got=%b exp=1", hazard_stall); end
    valid_in = 1'b0;
    #1;
    checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL hazard_novalid got=%b exp=0", hazard_stall); end
    tick();   // valid_in low loads a bubble
    checks++; if (valid_exec !== 1'b0 || reg_write_exec !== 1'b0 || rd_exec !== 5'd0) begin failures++; $display("FAIL bubble got=%b%b/%0d exp=00/0", valid_exec, reg_write_exec, rd_exec); end
    issue(32'h00002003, 32'h308);   // lw x0,0(x0)
    tick();
    issue(32'h00108133, 32'h30C);
    #1;
    checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL hazard_rd0 got=%b exp=0", hazard_stall); end
  endtask

  task automatic test_stall_flush;
    issue(32'h402081B3, 32'h400);   // sub x3,x1,x2
    tick();
    stall = 1'b1;
    issue(32'h00500093, 32'h404);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rd_exec !== 5'd3 || alu_ctrl_exec !== 4'd1 || pc_exec !== 32'h400 || valid_exec !== 1'b1) begin failures++; $display("FAIL stall_hold%0d got=%0d/%0d/%h/%b exp=3/1/400/1", i, rd_exec, alu_ctrl_exec, pc_exec, valid_exec); end
    end
    stall = 1'b0;
    tick();
    checks++; if (rd_exec !== 5'd1 || pc_exec !== 32'h404) begin failures++; $display("FAIL stall_release got=%0d/%h exp=1/404", rd_exec, pc_exec); end
    flush = 1'b1; stall = 1'b1;
    issue(32'h0020A423, 32'h408);
    tick();
    flush = 1'b0; stall = 1'b0;
    checks++; if ({valid_exec, reg_write_exec, mem_read_exec, mem_write_exec, branch_exec, jump_exec, illegal_exec, alu_src_exec} !== 8'd0) begin failures++; $display("FAIL flush_flags got=%b exp=0", {valid_exec, reg_write_exec, mem_read_exec, mem_write_exec, branch_exec, jump_exec, illegal_exec, alu_src_exec}); end
    checks++; if (imm_exec !== 32'd0 || pc_exec !== 32'd0 || rd_exec !== 5'd0) begin failures++; $display("FAIL flush_data got=%h/%h/%0d exp=0/0/0", imm_exec, pc_exec, rd_exec); end
  endtask

  task automatic test_x0;
    reg_write_wb = 1'b1; rd_wb = 5'd0; result_wb = 32'hFFFF0000;
    issue(32'h00000133, 32'h500);   // add x2,x0,x0
    tick();
    reg_write_wb = 1'b0;
    checks++; if (rs1_data_exec !== 32'd0 || rs2_data_exec !== 32'd0) begin failures++; $display("FAIL x0_wt got=%h/%h exp=0/0", rs1_data_exec, rs2_data_exec); end
    tick();
    checks++; if (rs1_data_exec !== 32'd0) begin failures++; $display("FAIL x0_stored got=%h exp=0", rs1_data_exec); end
  endtask

  task automatic test_reset_midstream;
    reg_write_wb = 1'b1; rd_wb = 5'd5; result_wb = 32'hDEADBEEF;
    issue(32'h00500093, 32'h600);
    tick();
    reg_write_wb = 1'b0;
    issue(32'h00528333, 32'h604);   // add x6,x5,x5
    tick();
    checks++; if (rs1_data_exec !== 32'hDEADBEEF) begin failures++; $display("FAIL x5_written got=%h exp=deadbeef", rs1_data_exec); end
    reset = 1'b1; reg_write_wb = 1'b1; rd_wb = 5'd5; result_wb = 32'h11111111;
    tick();
    reset = 1'b0; reg_write_wb = 1'b0; valid_in = 1'b0;
    checks++; if ({rs1_data_exec, imm_exec, pc_exec, rd_exec, alu_ctrl_exec, valid_exec, reg_write_exec} !== 107'd0) begin failures++; $display("FAIL midreset_out got=%h exp=0", {rs1_data_exec, imm_exec, pc_exec, rd_exec, alu_ctrl_exec, valid_exec, reg_write_exec}); end
    issue(32'h00528333, 32'h608);
    tick();
    checks++; if (rs1_data_exec !== 32'd0 || rs2_data_exec !== 32'd0 || valid_exec !== 1'b1) begin failures++; $display("FAIL x5_cleared got=%h/%h/%b exp=0/0/1", rs1_data_exec, rs2_data_exec, valid_exec); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_writethrough();
    test_store_illegal();
    test_formats();
    test_hazard();
    test_stall_flush();
    test_x0();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
# instr_decode

RV32I decode stage. Sits directly downstream of the instruction fetch stage and consumes its registered instruction, PC, PC+4 and valid outputs. Contains the 32×32 register file with write-through from writeback, immediate generation, and control decode. Also raises a load-use hazard request. Results are registered into the decode/execute pipeline register.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `NREGS`, 32: register count; x0 is hardwired to zero.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; clears the pipeline register and register file.
- `flush` in 1: insert a bubble into the execute register next edge.
- `stall` in 1: hold the execute register.
- `instr_in` in 32: instruction from fetch.
- `pc_in` in 32: PC of `instr_in`.
- `next_pc_in` in 32: PC+4 of `instr_in`.
- `valid_in` in 1: fetch output valid.
- `reg_write_wb` in 1: writeback enable.
- `rd_wb` in 5: writeback destination.
- `result_wb` in 32: writeback data.
- `rs1_data_exec` out 32: rs1 operand.
- `rs2_data_exec` out 32: rs2 operand.
- `imm_exec` out 32: sign-extended immediate.
- `rs1_exec` out 5, `rs2_exec` out 5, `rd_exec` out 5: register indices (for forwarding).
- `funct3_exec` out 3: raw funct3 (branch/load/store sizing).
- `alu_ctrl_exec` out 4: ALU op.
- `alu_src_exec` out 1: B operand; 0 = rs2, 1 = imm.
- `alu_a_pc_exec` out 1: A operand is PC (AUIPC, JAL).
- `result_src_exec` out 2: 0 = ALU, 1 = memory, 2 = PC+4.
- `reg_write_exec` out 1, `mem_read_exec` out 1, `mem_write_exec` out 1, `branch_exec` out 1, `jump_exec` out 1: control flags.
- `illegal_exec` out 1: unrecognised opcode or funct.
- `pc_exec` out 32, `next_pc_exec` out 32: forwarded PCs.
- `valid_exec` out 1: execute register holds a real instruction.
- `hazard_stall` out 1: combinational load-use stall request to the pipeline controller.

## Operation
- Decode is combinational from `instr_in`; everything is captured into the execute register.
- Supported opcodes:
  - LUI: ALU PASS_B, imm U.
  - AUIPC: `alu_a_pc_exec`=1, imm U, ADD.
  - JAL: jump, `result_src_exec`=2, imm J.
  - JALR: jump, `alu_src_exec`=1, imm I, `result_src_exec`=2.
  - BRANCH: branch, ALU SUB, imm B.
  - LOAD: `mem_read_exec`, `result_src_exec`=1, imm I.
  - STORE: `mem_write_exec`, imm S, `reg_write_exec`=0.
  - OP-IMM: `alu_src_exec`=1; SRAI is selected by `instr[30]`.
  - OP: SUB/SRA are selected by `instr[30]`.
- Anything else, including OP with `funct7` other than 0x00/0x20, sets `illegal_exec`=1. An illegal instruction forces all write/mem/branch/jump flags to 0.
- Register file:
  - Read asynchronously by rs1/rs2.
  - Written on the rising edge when `reg_write_wb` is set and `rd_wb`≠0.
  - x0 always reads 0.
  - Write-through: when `reg_write_wb`, `rd_wb`≠0 and `rd_wb` equals rs1 (or rs2), that read port returns `result_wb` in the same cycle.
- `hazard_stall` = `valid_in` & `valid_exec` & `mem_read_exec` & `rd_exec`≠0 & (`rd_exec`==rs1 | `rd_exec`==rs2). The flag is raised regardless of whether the instruction actually uses rs2; this conservative stall is accepted.
- Priority at each edge: `reset` > `flush` > `stall` > load.
  - Flush and bubble: all control flags, `valid_exec` and `illegal_exec` go to 0; data fields go to 0.
  - Stall: the execute register holds. Register file writes proceed regardless of stall and flush.
- `valid_in`=0: load a bubble, not the decoded word.

## Timing
- One-cycle latency: `instr_in` sampled at edge N appears on the `*_exec` outputs after edge N.
- Reset: every `*_exec` output is 0, all 32 registers are 0, and `hazard_stall`=0 (since `valid_exec`=0).
- Reset asserted mid-stream: the next edge clears all state. An in-flight writeback on that edge is discarded.
- `flush` and `stall` together: bubble (flush wins).
- Writeback and decode reading the same register in the same cycle: the new value is used.
- Immediates are sign-extended from `instr[31]`. The B and J immediates have bit 0 = 0.

## Structure
- Shared package `riscv_pkg` holds:
  - Opcode constants.
  - `alu_ctrl` encodings: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10.
  - `result_src` encodings.
  - `XLEN`.
- One sub-module, `reg_file`: two asynchronous read ports with write-through, one synchronous write port, synchronous reset.
- Decoder and immediate generation stay in `instr_decode`.

## Test plan
- Reset, then `instr_in`=0x00500093 (addi x1,x0,5) with `valid_in`=1 → after 1 edge: `imm_exec`=5, `rd_exec`=1, `alu_ctrl_exec`=ADD, `alu_src_exec`=1, `reg_write_exec`=1, `valid_exec`=1.
- Writeback x1=0x00001234 in the same cycle as 0x00108133 (add x2,x1,x1) → `rs1_data_exec`=`rs2_data_exec`=0x00001234.
- 0x0020A423 (sw x2,8(x1)) → `imm_exec`=8, `mem_write_exec`=1, `reg_write_exec`=0. 0xFFFFFFFF → `illegal_exec`=1 and all enables 0.
- Execute holds lw with rd=1 while decode sees add x2,x1,x1 → `hazard_stall`=1. With rd=0 → `hazard_stall`=0.
- Asserting `stall` holds all outputs for 3 cycles. `flush`+`stall` together → `valid_exec`=0 and all flags 0. A writeback to x0 leaves x0 reading 0.
- Asserting `reset` mid-stream after writing x5=0xDEADBEEF → all outputs 0, and x5 reads 0 afterwards.
